regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Writeback arbiter between two execution result sources (ALU, LSU) and the single write port of the 2-read/1-write integer register file. Each source has a one-entry holding register behind a valid/ready handshake; one pending entry per cycle drives the register-file write port, oldest first. Writes to x0 are discarded at acceptance. Per-read-port hazard flags tell decode when a source register still has a pending write.

## Interface
- DLEN, 32, data width; must match register-file DLEN
- ALEN, 5, register address width; must match register-file ALEN
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU holding register can accept
- i_alu_rd  in  ALEN  ALU destination register
- i_alu_data  in  DLEN  ALU result
- i_lsu_valid  in  1  LSU result valid
- o_lsu_ready  out  1  LSU holding register can accept
- i_lsu_rd  in  ALEN  LSU destination register
- i_lsu_data  in  DLEN  LSU load data
- o_wen  out  1  register-file write enable
- o_waddr  out  ALEN  register-file write address
- o_wdata  out  DLEN  register-file write data
- i_raddr_a  in  ALEN  decode read address A (hazard check)
- i_raddr_b  in  ALEN  decode read address B (hazard check)
- o_hazard_a  out  1  pending write to i_raddr_a
- o_hazard_b  out  1  pending write to i_raddr_b

## Operation
- State per source s: hold_v, hold_rd, hold_data, age bit older_s; plus round-robin pointer rr (0=ALU first, 1=LSU first).
- Accept: transfer on rising edge when valid & ready. o_s_ready = ~hold_v_s | grant_s (drain and refill same cycle allowed).
- x0 drop: valid with rd==0 is accepted (ready per rule above) but never captured; hold_v unchanged unless drained.
- Arbitration (combinational, registered state): if one holder valid, grant it; if both valid, grant the one with older=1; if neither older (captured same edge), grant per rr, then toggle rr.
- Age: on capture into s while other holder already valid and not drained this edge, older_other<=1, older_s<=0. Capture into both same edge: both older<=0. Drain of s clears older_s and sets nothing.
- Write port: o_wen = grant_any; o_waddr/o_wdata = granted holder's rd/data; both driven 0 when o_wen=0.
- Hazard: o_hazard_x = (i_raddr_x != 0) & OR over holders of (hold_v & hold_rd == i_raddr_x). Incoming unaccepted source data is not included.
- Same rd in both holders: oldest-first guarantees program-order write; no merging.

## Timing
- Reset (async assert, sync release): hold_v=0, older=0, rr=0, o_wen=0, o_waddr=0, o_wdata=0, o_hazard_a/b=0, o_alu_ready=o_lsu_ready=1.
- Latency: accepted at edge N -> o_wen high in cycle N..N+1, register file updated at edge N+1 (if granted). Blocked holder waits at most one extra cycle.
- Throughput: one register-file write per cycle; each source sustains one result/cycle only when the other is idle.
- Reset mid-operation: pending holders discarded, no write issued after rst_n asserts; o_wen falls asynchronously.
- No combinational path from i_*_valid to o_wen; ready depends combinationally only on internal state.

## Test plan
- Reset: assert rst_n=0 with both valid -> all outputs at reset values, both ready=1, no capture.
- Single ALU: rd=5, data=0xDEADBEEF at edge 1 -> cycle after: o_wen=1, o_waddr=5, o_wdata=0xDEADBEEF, o_hazard_a=1 for raddr_a=5; next cycle o_wen=0.
- Simultaneous capture: ALU rd=3/0x11, LSU rd=4/0x22 same edge with rr=0 -> ALU written first, LSU next cycle, rr=1; repeat -> LSU first.
- Age order: LSU rd=7/0xAA captured, next cycle ALU busy stalls, then ALU rd=7/0xBB -> LSU entry written before ALU; final x7=0xBB.
- x0 drop: ALU rd=0/0xFFFF valid -> ready=1, o_wen stays 0, o_hazard_a=0 for raddr_a=0.
- Back-pressure: both sources valid every cycle for 10 cycles -> exactly one write per cycle, alternating grants, each source ready deasserted only while holder full and not granted, no lost or duplicated data.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two one-entry holding registers (ALU, LSU) sharing the
// single register-file write port. The oldest pending entry is written first;
// ties from a same-edge capture are broken by a round-robin pointer. Writes to
// x0 are accepted but never captured. Hazard flags report pending writes that
// target the decode read addresses.
module regfile_wb_arbiter #(
    parameter int unsigned DLEN = 32,
    parameter int unsigned ALEN = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_alu_valid,
    output logic            o_alu_ready,
    input  logic [ALEN-1:0] i_alu_rd,
    input  logic [DLEN-1:0] i_alu_data,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [ALEN-1:0] i_lsu_rd,
    input  logic [DLEN-1:0] i_lsu_data,
    output logic            o_wen,
    output logic [ALEN-1:0] o_waddr,
    output logic [DLEN-1:0] o_wdata,
    input  logic [ALEN-1:0] i_raddr_a,
    input  logic [ALEN-1:0] i_raddr_b,
    output logic            o_hazard_a,
    output logic            o_hazard_b
);

    logic            r_alu_v,     w_alu_v_d;
    logic [ALEN-1:0] r_alu_rd;
    logic [DLEN-1:0] r_alu_data;
    logic            r_alu_older, w_alu_older_d;
    logic            r_lsu_v,     w_lsu_v_d;
    logic [ALEN-1:0] r_lsu_rd;
    logic [DLEN-1:0] r_lsu_data;
    logic            r_lsu_older, w_lsu_older_d;
    logic            r_rr,        w_rr_d;

    logic w_tie;
    logic w_grant_alu;
    logic w_grant_lsu;
    logic w_alu_cap;
    logic w_lsu_cap;

    // Grant and ready decode from registered state only.
    always_comb begin
        w_tie       = r_alu_v & r_lsu_v & ~r_alu_older & ~r_lsu_older;
        w_grant_alu = r_alu_v & (~r_lsu_v | r_alu_older | (w_tie & ~r_rr));
        w_grant_lsu = r_lsu_v & ~w_grant_alu;
        o_alu_ready = ~r_alu_v | w_grant_alu;
        o_lsu_ready = ~r_lsu_v | w_grant_lsu;
        // x0 results complete the handshake but are not captured.
        w_alu_cap   = i_alu_valid & o_alu_ready & (i_alu_rd != '0);
        w_lsu_cap   = i_lsu_valid & o_lsu_ready & (i_lsu_rd != '0);
    end

    // Next-state for holder valid bits, age bits and round-robin pointer.
    always_comb begin
        w_alu_v_d     = r_alu_v;
        w_lsu_v_d     = r_lsu_v;
        w_alu_older_d = r_alu_older;
        w_lsu_older_d = r_lsu_older;
        w_rr_d        = r_rr;

        if (w_grant_alu) begin
            w_alu_v_d     = 1'b0;
            w_alu_older_d = 1'b0;
        end
        if (w_grant_lsu) begin
            w_lsu_v_d     = 1'b0;
            w_lsu_older_d = 1'b0;
        end
        if (w_alu_cap) begin
            w_alu_v_d     = 1'b1;
            w_alu_older_d = 1'b0;
        end
        if (w_lsu_cap) begin
            w_lsu_v_d     = 1'b1;
            w_lsu_older_d = 1'b0;
        end
        // A fresh capture makes a surviving entry in the other holder the older one.
        if (w_alu_cap && r_lsu_v && !w_grant_lsu) begin
            w_lsu_older_d = 1'b1;
        end
        if (w_lsu_cap && r_alu_v && !w_grant_alu) begin
            w_alu_older_d = 1'b1;
        end
        // A tie is always resolved by a grant, so flip the pointer for fairness.
        if (w_tie) begin
            w_rr_d = ~r_rr;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_v     <= 1'b0;
            r_lsu_v     <= 1'b0;
            r_alu_older <= 1'b0;
            r_lsu_older <= 1'b0;
            r_rr        <= 1'b0;
        end else begin
            r_alu_v     <= w_alu_v_d;
            r_lsu_v     <= w_lsu_v_d;
            r_alu_older <= w_alu_older_d;
            r_lsu_older <= w_lsu_older_d;
            r_rr        <= w_rr_d;
        end
    end

    // Holding register payload, loaded only on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_rd   <= '0;
            r_alu_data <= '0;
            r_lsu_rd   <= '0;
            r_lsu_data <= '0;
        end else begin
            if (w_alu_cap) begin
                r_alu_rd   <= i_alu_rd;
                r_alu_data <= i_alu_data;
            end
            if (w_lsu_cap) begin
                r_lsu_rd   <= i_lsu_rd;
                r_lsu_data <= i_lsu_data;
            end
        end
    end

    // Write port mux and read-address hazard detection.
    always_comb begin
        o_wen   = w_grant_alu | w_grant_lsu;
        o_waddr = '0;
        o_wdata = '0;
        if (w_grant_alu) begin
            o_waddr = r_alu_rd;
            o_wdata = r_alu_data;
        end else if (w_grant_lsu) begin
            o_waddr = r_lsu_rd;
            o_wdata = r_lsu_data;
        end
        o_hazard_a = (i_raddr_a != '0) &
                     ((r_alu_v & (r_alu_rd == i_raddr_a)) | (r_lsu_v & (r_lsu_rd == i_raddr_a)));
        o_hazard_b = (i_raddr_b != '0) &
                     ((r_alu_v & (r_alu_rd == i_raddr_b)) | (r_lsu_v & (r_lsu_rd == i_raddr_b)));
    end

endmodule
